// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: turns one-cycle direction pulses into a head position that
// advances one grid cell per movement tick, with single-entry pending turn.
//
// state | meaning
// IDLE  | waiting for the first direction pulse, no movement
// RUN   | tick divider running, head moves one cell per tick
module snake_head_ctrl #(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int TICK_CYCLES = 25_000_000,
  parameter int X0          = 0,
  parameter int Y0          = 0,
  parameter int WRAP        = 1,
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          L,
  input  logic          R,
  input  logic          U,
  input  logic          D,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir,
  output logic          moving,
  output logic          step,
  output logic          wall_hit
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] DIR_U = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_L = 2'b11;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_RST     = XW'(X0);
  localparam logic [YW-1:0] Y_RST     = YW'(Y0);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          pend_valid;
  logic [1:0]    pend_dir;

  logic          pulse_any;
  logic [1:0]    pulse_dir;
  logic          turn_ok;
  logic          tick;
  logic [1:0]    new_dir;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          blocked;

  // Pulse priority U > R > D > L, turn filter against the committed direction,
  // and the direction that takes effect on this tick.
  always_comb begin
    pulse_any = U | R | D | L;
    if (U)      pulse_dir = DIR_U;
    else if (R) pulse_dir = DIR_R;
    else if (D) pulse_dir = DIR_D;
    else        pulse_dir = DIR_L;
    // reverse of a direction is obtained by flipping bit 1
    turn_ok = pulse_any && (pulse_dir != dir) && (pulse_dir != (dir ^ 2'b10));
    tick    = (state == RUN) && (tick_cnt == TICK_LAST);
    if (turn_ok)         new_dir = pulse_dir;
    else if (pend_valid) new_dir = pend_dir;
    else                 new_dir = dir;
  end

  // Candidate next head position for new_dir; edges wrap or block.
  always_comb begin
    next_x  = head_x;
    next_y  = head_y;
    blocked = 1'b0;
    case (new_dir)
      DIR_U: begin
        if (head_y == '0) begin
          if (WRAP != 0) next_y = Y_LAST;
          else           blocked = 1'b1;
        end else begin
          next_y = head_y - 1'b1;
        end
      end
      DIR_D: begin
        if (head_y == Y_LAST) begin
          if (WRAP != 0) next_y = '0;
          else           blocked = 1'b1;
        end else begin
          next_y = head_y + 1'b1;
        end
      end
      DIR_L: begin
        if (head_x == '0) begin
          if (WRAP != 0) next_x = X_LAST;
          else           blocked = 1'b1;
        end else begin
          next_x = head_x - 1'b1;
        end
      end
      default: begin
        if (head_x == X_LAST) begin
          if (WRAP != 0) next_x = '0;
          else           blocked = 1'b1;
        end else begin
          next_x = head_x + 1'b1;
        end
      end
    endcase
  end

  // Control FSM with tick divider, pending turn and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      head_x     <= X_RST;
      head_y     <= Y_RST;
      dir        <= DIR_R;
      moving     <= 1'b0;
      step       <= 1'b0;
      wall_hit   <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_R;
      tick_cnt   <= '0;
    end else begin
      step     <= 1'b0;
      wall_hit <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (pulse_any) begin
            dir    <= pulse_dir;
            state  <= RUN;
            moving <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            tick_cnt   <= '0;
            dir        <= new_dir;
            pend_valid <= 1'b0;
            if (blocked) begin
              wall_hit <= 1'b1;
            end else begin
              head_x <= next_x;
              head_y <= next_y;
              step   <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (turn_ok) begin
              pend_valid <= 1'b1;
              pend_dir   <= pulse_dir;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: a 4x4 wrapping instance driven from a vector
// table, plus a non-wrapping instance exercised by a hand-written sequence.
module tb_snake_head_ctrl;

  logic clk = 1'b0;
  logic reset, L, R, U, D;

  logic [1:0] ax, ay, adir, bx, by, bdir;
  logic       amov, astep, awall, bmov, bstep, bwall;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_head_ctrl #(.COLS(4), .ROWS(4), .TICK_CYCLES(4), .X0(0), .Y0(0), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D),
    .head_x(ax), .head_y(ay), .dir(adir), .moving(amov), .step(astep), .wall_hit(awall)
  );

  snake_head_ctrl #(.COLS(4), .ROWS(4), .TICK_CYCLES(4), .X0(0), .Y0(0), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D),
    .head_x(bx), .head_y(by), .dir(bdir), .moving(bmov), .step(bstep), .wall_hit(bwall)
  );

  typedef struct {
    logic rst, l, r, u, d;
    logic [1:0] x, y, dr;
    logic mov, stp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, l_i, r_i, u_i, d_i,
                     input logic [1:0] x, y, dr, input logic mov, stp);
    vec_t v;
    v.rst = rs; v.l = l_i; v.r = r_i; v.u = u_i; v.d = d_i;
    v.x = x; v.y = y; v.dr = dr; v.mov = mov; v.stp = stp;
    vecs.push_back(v);
  endtask

  // n quiet cycles in RUN with no expected move
  task automatic idle(input int n, input logic [1:0] x, y, dr);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, x, y, dr, 1, 0);
  endtask

  // n quiet cycles in IDLE at the reset position
  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 0, 0);
  endtask

  task automatic drive(input logic rs, l_i, r_i, u_i, d_i);
    reset = rs; L = l_i; R = r_i; U = u_i; D = d_i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic [1:0] x, y, dr,
                       input logic mov, stp, wl);
    n_vec++;
    if ({bx, by, bdir, bmov, bstep, bwall} !== {x, y, dr, mov, stp, wl}) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d dir=%0d mov=%0b step=%0b wall=%0b, want x=%0d y=%0d dir=%0d mov=%0b step=%0b wall=%0b",
               name, bx, by, bdir, bmov, bstep, bwall, x, y, dr, mov, stp, wl);
    end
  endtask

  initial begin
    reset = 1'b1; L = 1'b0; R = 1'b0; U = 1'b0; D = 1'b0;

    // reset and quiet idle
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle0(20);
    // R pulse: run right with wrap 3 -> 0
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    idle(3, 0, 0, 1); add(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    idle(3, 1, 0, 1); add(0, 0, 0, 0, 0, 2, 0, 1, 1, 1);
    idle(3, 2, 0, 1); add(0, 0, 0, 0, 0, 3, 0, 1, 1, 1);
    idle(3, 3, 0, 1); add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    // reverse L ignored, U pending, wrap up 0 -> 3
    add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    idle(1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    // pending last-wins: R then L -> left, wrap x 0 -> 3
    add(0, 0, 1, 0, 0, 0, 3, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 3, 0, 1, 0);
    idle(1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 3, 3, 3, 1, 1);
    // pending D overridden by U pulsed in the tick cycle
    idle(2, 3, 3, 3);
    add(0, 0, 0, 0, 1, 3, 3, 3, 1, 0);
    add(0, 0, 0, 1, 0, 3, 2, 0, 1, 1);
    // filter uses committed dir (up): R then L both accepted, L wins
    add(0, 0, 1, 0, 0, 3, 2, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3, 2, 0, 1, 0);
    idle(1, 3, 2, 0);
    add(0, 0, 0, 0, 0, 2, 2, 3, 1, 1);
    // pending D kept when tick-cycle pulse R is a reversal
    add(0, 0, 0, 0, 1, 2, 2, 3, 1, 0);
    idle(2, 2, 2, 3);
    add(0, 0, 1, 0, 0, 2, 3, 2, 1, 1);
    // down wrap y 3 -> 0
    idle(3, 2, 3, 2);
    add(0, 0, 0, 0, 0, 2, 0, 2, 1, 1);
    // pending R, then reset mid-run, then quiet
    add(0, 0, 1, 0, 0, 2, 0, 2, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle0(12);
    // U and L together from IDLE: U wins, pending from before reset gone
    add(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    idle(3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 1, 1);
    // reset, then L from IDLE (no reversal check), wrap x 0 -> 3
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 3, 1, 0);
    idle(3, 0, 0, 3);
    add(0, 0, 0, 0, 0, 3, 0, 3, 1, 1);
    // U and D together in RUN: U wins
    add(0, 0, 0, 1, 1, 3, 0, 3, 1, 0);
    idle(2, 3, 0, 3);
    add(0, 0, 0, 0, 0, 3, 3, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d);
      n_vec++;
      if ({ax, ay, adir, amov, astep, awall} !==
          {vecs[i].x, vecs[i].y, vecs[i].dr, vecs[i].mov, vecs[i].stp, 1'b0}) begin
        n_bad++;
        $display("FAIL vec %0d: got x=%0d y=%0d dir=%0d mov=%0b step=%0b wall=%0b, want x=%0d y=%0d dir=%0d mov=%0b step=%0b wall=0",
                 i, ax, ay, adir, amov, astep, awall,
                 vecs[i].x, vecs[i].y, vecs[i].dr, vecs[i].mov, vecs[i].stp);
      end
    end

    // non-wrapping instance: blocked moves at the right and top edges
    drive(1, 0, 0, 0, 0);
    chk_b("b_reset", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk_b("b_start", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0);
    chk_b("b_reach_x3", 3, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    chk_b("b_pre_wall", 3, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_b("b_wall_right", 3, 0, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk_b("b_wall_one_cycle", 3, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_b("b_wall_up", 3, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    chk_b("b_after_wall_up", 3, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
